// File: rtl/filter_test_sequencer.sv
// Delay-sweep test sequencer: steps the pulse generator through a delay range and
// captures the signed peak value and position of one filter output per sweep point.
module filter_test_sequencer #(
    parameter int SIZE_DELAY = 8,
    parameter int SIZE_DATA  = 16,
    parameter int SIZE_CNT   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_overlay,
    input  logic [SIZE_DELAY-1:0] cfg_delay_start,
    input  logic [SIZE_DELAY-1:0] cfg_delay_end,
    input  logic [SIZE_DELAY-1:0] cfg_delay_inc,
    input  logic [SIZE_CNT-1:0]   cfg_settle,
    input  logic [SIZE_CNT-1:0]   cfg_measure,
    input  logic [SIZE_DATA-1:0]  filter_data,
    output logic                  test_overlay,
    output logic                  test_rate,
    output logic [SIZE_DELAY-1:0] test_delay,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [SIZE_DELAY-1:0] result_delay,
    output logic [SIZE_DATA-1:0]  result_peak,
    output logic [SIZE_CNT-1:0]   result_pos,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_overlay;
    logic [SIZE_DELAY-1:0] r_end;
    logic [SIZE_DELAY-1:0] r_inc;
    logic [SIZE_CNT-1:0]   r_settle;
    logic [SIZE_CNT-1:0]   r_measure;
    logic [SIZE_DELAY-1:0] r_cur;
    logic [SIZE_CNT-1:0]   r_cnt;
    logic [SIZE_DATA-1:0]  r_peak;
    logic [SIZE_CNT-1:0]   r_pos;

    logic [SIZE_DELAY:0]   w_next;
    logic                  w_sweep_end;
    logic                  w_settle_last;
    logic                  w_meas_last;
    logic                  w_take;
    logic [SIZE_DATA-1:0]  w_peak;
    logic [SIZE_CNT-1:0]   w_pos;

    // r_inc and r_measure hold the already-corrected (nonzero) values
    assign w_next        = {1'b0, r_cur} + {1'b0, r_inc};
    assign w_sweep_end   = w_next[SIZE_DELAY] || (w_next > {1'b0, r_end});
    assign w_settle_last = (r_cnt == r_settle - SIZE_CNT'(1));
    assign w_meas_last   = (r_cnt == r_measure - SIZE_CNT'(1));
    assign w_take        = (r_cnt == '0) ||
                           ($signed(filter_data) > $signed(r_peak));
    assign w_peak        = w_take ? filter_data : r_peak;
    assign w_pos         = w_take ? r_cnt : r_pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_overlay    <= 1'b0;
            r_end        <= '0;
            r_inc        <= '0;
            r_settle     <= '0;
            r_measure    <= '0;
            r_cur        <= '0;
            r_cnt        <= '0;
            r_peak       <= '0;
            r_pos        <= '0;
            test_overlay <= 1'b0;
            test_rate    <= 1'b0;
            test_delay   <= '0;
            result_valid <= 1'b0;
            result_delay <= '0;
            result_peak  <= '0;
            result_pos   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (abort && r_state != S_IDLE) begin
            r_state      <= S_IDLE;
            test_overlay <= 1'b0;
            test_rate    <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        r_overlay    <= cfg_overlay;
                        r_end        <= cfg_delay_end;
                        r_inc        <= (cfg_delay_inc == '0) ? SIZE_DELAY'(1) : cfg_delay_inc;
                        r_settle     <= cfg_settle;
                        r_measure    <= (cfg_measure == '0) ? SIZE_CNT'(1) : cfg_measure;
                        r_cur        <= cfg_delay_start;
                        r_cnt        <= '0;
                        test_delay   <= cfg_delay_start;
                        test_overlay <= cfg_overlay;
                        test_rate    <= 1'b1;
                        busy         <= 1'b1;
                        r_state      <= (cfg_settle == '0) ? S_MEASURE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_settle_last) begin
                        r_cnt   <= '0;
                        r_state <= S_MEASURE;
                    end else begin
                        r_cnt <= r_cnt + SIZE_CNT'(1);
                    end
                end
                S_MEASURE: begin
                    r_peak <= w_peak;
                    r_pos  <= w_pos;
                    if (w_meas_last) begin
                        result_valid <= 1'b1;
                        result_delay <= r_cur;
                        result_peak  <= w_peak;
                        result_pos   <= w_pos;
                        test_rate    <= 1'b0;
                        r_state      <= S_REPORT;
                    end else begin
                        r_cnt <= r_cnt + SIZE_CNT'(1);
                    end
                end
                S_REPORT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (w_sweep_end) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cur      <= w_next[SIZE_DELAY-1:0];
                            test_delay <= w_next[SIZE_DELAY-1:0];
                            test_rate  <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= (r_settle == '0) ? S_MEASURE : S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    test_overlay <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Directed bench for filter_test_sequencer: sweep stepping, peak capture,
// backpressure, degenerate configs, abort/reset and config isolation.
module tb_filter_test_sequencer;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic              cfg_overlay;
    logic [7:0]        cfg_delay_start;
    logic [7:0]        cfg_delay_end;
    logic [7:0]        cfg_delay_inc;
    logic [15:0]       cfg_settle;
    logic [15:0]       cfg_measure;
    logic signed [15:0] filter_data;
    logic              test_overlay;
    logic              test_rate;
    logic [7:0]        test_delay;
    logic              result_valid;
    logic              result_ready;
    logic [7:0]        result_delay;
    logic signed [15:0] result_peak;
    logic [15:0]       result_pos;
    logic              busy;
    logic              done;

    int checks = 0;
    int failures = 0;

    int q_del[$];
    int last_peak;
    int last_pos;
    int nres, nbusy, ndone;

    int va[5] = '{-5, 7, 3, 7, -1};
    int vb[5] = '{-9, -3, -3, -9, -9};

    filter_test_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .cfg_overlay     (cfg_overlay),
        .cfg_delay_start (cfg_delay_start),
        .cfg_delay_end   (cfg_delay_end),
        .cfg_delay_inc   (cfg_delay_inc),
        .cfg_settle      (cfg_settle),
        .cfg_measure     (cfg_measure),
        .filter_data     (filter_data),
        .test_overlay    (test_overlay),
        .test_rate       (test_rate),
        .test_delay      (test_delay),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_delay    (result_delay),
        .result_peak     (result_peak),
        .result_pos      (result_pos),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic ov, input int ds, input int de,
                           input int di, input int st, input int ms);
        cfg_overlay     = ov;
        cfg_delay_start = 8'(ds);
        cfg_delay_end   = 8'(de);
        cfg_delay_inc   = 8'(di);
        cfg_settle      = 16'(st);
        cfg_measure     = 16'(ms);
    endtask

    // Pulses start and watches the sweep with result_ready held high.
    // At iteration 'disturb' the cfg inputs change and start is pulsed again.
    task automatic run_sweep(input int disturb);
        int i;
        q_del.delete();
        nres = 0; nbusy = 0; ndone = 0;
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (i = 0; i < 300; i++) begin
            if (busy) nbusy++;
            if (done) ndone++;
            if (result_valid && result_ready) begin
                nres++;
                q_del.push_back(int'(result_delay));
                last_peak = int'(result_peak);
                last_pos  = int'(result_pos);
            end
            if (!busy) break;
            if (i == disturb) begin
                set_cfg(1'b0, 100, 200, 7, 9, 9);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("sweep_timeout", int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        result_ready = 1'b0;
        filter_data = '0;
        set_cfg(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_rate", int'(test_rate), 0);
        chk("rst_delay", int'(test_delay), 0);
        chk("rst_peak", int'(result_peak), 0);
        chk("rst_done", int'(done), 0);

        // Basic sweep
        set_cfg(1'b0, 0, 4, 2, 3, 5);
        run_sweep(-1);
        chk("basic_nres", nres, 3);
        chk("basic_busy", nbusy, 28);
        chk("basic_done", ndone, 1);
        chk("basic_d0", q_del.size() > 0 ? q_del[0] : -1, 0);
        chk("basic_d1", q_del.size() > 1 ? q_del[1] : -1, 2);
        chk("basic_d2", q_del.size() > 2 ? q_del[2] : -1, 4);

        // Peak/tie, backpressure, second point all-negative
        tick();
        set_cfg(1'b1, 10, 11, 1, 2, 5);
        result_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("st_busy", int'(busy), 1);
        chk("st_rate", int'(test_rate), 1);
        chk("st_delay", int'(test_delay), 10);
        chk("st_ovl", int'(test_overlay), 1);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            filter_data = 16'(va[k]);
            tick();
        end
        chk("pk_valid", int'(result_valid), 1);
        chk("pk_peak", int'(result_peak), 7);
        chk("pk_pos", int'(result_pos), 1);
        chk("pk_delay", int'(result_delay), 10);
        for (int k = 0; k < 10; k++) begin
            filter_data = 16'(k * 100);
            tick();
            chk("bp_valid", int'(result_valid), 1);
            chk("bp_peak", int'(result_peak), 7);
            chk("bp_pos", int'(result_pos), 1);
            chk("bp_rate", int'(test_rate), 0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("hs_valid", int'(result_valid), 0);
        chk("hs_rate", int'(test_rate), 1);
        chk("hs_delay", int'(test_delay), 11);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            filter_data = 16'(vb[k]);
            tick();
        end
        chk("neg_valid", int'(result_valid), 1);
        chk("neg_peak", int'(result_peak), -3);
        chk("neg_pos", int'(result_pos), 1);
        chk("neg_delay", int'(result_delay), 11);
        result_ready = 1'b1;
        tick();
        chk("end_done", int'(done), 1);
        chk("end_valid", int'(result_valid), 0);
        tick();
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ovl", int'(test_overlay), 0);
        chk("idle_delay", int'(test_delay), 11);

        // Overflow of the delay field
        filter_data = 16'sd123;
        set_cfg(1'b0, 250, 255, 4, 0, 1);
        run_sweep(-1);
        chk("ovf_nres", nres, 2);
        chk("ovf_d0", q_del.size() > 0 ? q_del[0] : -1, 250);
        chk("ovf_d1", q_del.size() > 1 ? q_del[1] : -1, 254);

        // end < start
        set_cfg(1'b0, 9, 3, 1, 1, 2);
        run_sweep(-1);
        chk("rev_nres", nres, 1);
        chk("rev_d0", q_del.size() > 0 ? q_del[0] : -1, 9);

        // inc = 0
        set_cfg(1'b0, 5, 7, 0, 1, 1);
        run_sweep(-1);
        chk("inc0_nres", nres, 3);
        chk("inc0_d2", q_del.size() > 2 ? q_del[2] : -1, 7);

        // measure = 0, settle = 0
        set_cfg(1'b0, 0, 0, 1, 0, 0);
        run_sweep(-1);
        chk("m0_nres", nres, 1);
        chk("m0_busy", nbusy, 3);
        chk("m0_peak", last_peak, 123);
        chk("m0_pos", last_pos, 0);

        // Abort during MEASURE
        set_cfg(1'b0, 0, 4, 2, 2, 5);
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", int'(busy), 0);
        chk("ab_valid", int'(result_valid), 0);
        chk("ab_rate", int'(test_rate), 0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (done || busy) ndone++;
            tick();
        end
        chk("ab_quiet", ndone, 0);
        set_cfg(1'b0, 0, 4, 2, 3, 5);
        run_sweep(-1);
        chk("ab_rerun_nres", nres, 3);
        chk("ab_rerun_done", ndone, 1);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", int'(busy), 0);

        // Reset during REPORT
        set_cfg(1'b1, 33, 40, 1, 1, 1);
        result_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rr_valid_pre", int'(result_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_valid", int'(result_valid), 0);
        chk("rr_busy", int'(busy), 0);
        chk("rr_delay", int'(test_delay), 0);
        chk("rr_rdelay", int'(result_delay), 0);
        chk("rr_done", int'(done), 0);
        set_cfg(1'b0, 0, 4, 2, 3, 5);
        run_sweep(-1);
        chk("rr_rerun_nres", nres, 3);
        chk("rr_rerun_d2", q_del.size() > 2 ? q_del[2] : -1, 4);

        // Config isolation: cfg change and start mid-sweep
        set_cfg(1'b0, 0, 4, 2, 3, 5);
        run_sweep(5);
        chk("iso_nres", nres, 3);
        chk("iso_busy", nbusy, 28);
        chk("iso_d1", q_del.size() > 1 ? q_del[1] : -1, 2);
        chk("iso_d2", q_del.size() > 2 ? q_del[2] : -1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_test_sequencer.md
# filter_test_sequencer

Automatic test sequencer for the filter evaluation chain. It drives the pulse generator's `test_overlay`, `test_rate` and `test_delay` controls through a programmed delay sweep. At each sweep point it waits a settle window, then captures the signed peak value and peak position of one filter output over a measurement window. Each per-point result is returned to the readout side over a valid/ready handshake. It sits beside the filter top level, between the control/readout logic and the `exp_sig_gen` test inputs.

## Interface
- `SIZE_DELAY`, 8, width of `test_delay` and sweep configuration fields
- `SIZE_DATA`, 16, width of the monitored filter output, signed two's complement
- `SIZE_CNT`, 16, width of settle/measure counters and peak position
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE
- `abort`  in  1  terminate the sweep; return to IDLE on the next cycle
- `cfg_overlay`  in  1  overlay mode used for the whole sweep
- `cfg_delay_start`  in  SIZE_DELAY  first delay value
- `cfg_delay_end`  in  SIZE_DELAY  last delay value, inclusive
- `cfg_delay_inc`  in  SIZE_DELAY  delay increment; 0 is treated as 1
- `cfg_settle`  in  SIZE_CNT  settle cycles per point; 0 is allowed
- `cfg_measure`  in  SIZE_CNT  measured samples per point; 0 is treated as 1
- `filter_data`  in  SIZE_DATA  monitored filter output, signed
- `test_overlay`  out  1  to generator
- `test_rate`  out  1  to generator; 1 only in SETTLE/MEASURE
- `test_delay`  out  SIZE_DELAY  to generator
- `result_valid`  out  1  per-point result available
- `result_ready`  in  1  readout accepts the result
- `result_delay`  out  SIZE_DELAY  delay of the reported point
- `result_peak`  out  SIZE_DATA  maximum signed sample in the window
- `result_pos`  out  SIZE_CNT  sample index of the first occurrence of the maximum
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when a sweep completes normally

## Operation
- States: IDLE, SETTLE, MEASURE, REPORT, DONE.
- On `start` in IDLE, latch all `cfg_*` inputs; a running sweep never sees configuration changes. Load `cur_delay = cfg_delay_start`, then go to SETTLE.
- SETTLE: count `cfg_settle` cycles. If `cfg_settle` is 0, go directly to MEASURE, with the first sample taken on the cycle after leaving IDLE/REPORT.
- MEASURE: sample `filter_data` for `cfg_measure` cycles, using index 0..N-1.
  - Sample 0 initialises the peak.
  - A later sample replaces it only if it is strictly greater (signed), so ties keep the earliest index.
- REPORT: hold `result_valid`=1 with stable result fields until `result_ready`=1.
  - On the handshake cycle, compute `next = cur_delay + inc` in SIZE_DELAY+1 bits.
  - If `next > delay_end` or `next` overflows SIZE_DELAY, go to DONE. Otherwise load `next` and go to SETTLE.
- If `cfg_delay_end < cfg_delay_start`, the sweep is exactly one point, at `cfg_delay_start`.
- DONE: `done`=1 for one cycle, then IDLE.
- `abort` has priority over every transition except `reset`.
  - From any non-IDLE state, the next state is IDLE.
  - `result_valid` drops, `done` is not pulsed, and any pending result is discarded.
- `start` while busy is ignored; `start` and `abort` together in IDLE leaves the block in IDLE.
- Output drive:
  - `test_overlay` = latched overlay while busy, 0 in IDLE.
  - `test_delay` = `cur_delay` while busy; it holds its last value in IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `test_overlay`=0, `test_rate`=0, `test_delay`=0.
  - `result_valid`=0, `result_delay`=0, `result_peak`=0, `result_pos`=0.
  - `busy`=0, `done`=0.
- Reset mid-sweep behaves as `abort` and also clears all outputs to the values above.
- All outputs are registered.
- `start` at cycle t gives `busy`=1, `test_rate`=1 and `test_delay`=start at t+1.
- A point occupies `cfg_settle` + `cfg_measure` cycles, then REPORT begins. `result_valid` rises on the cycle after the last sample.
- The handshake completes on a cycle with `result_valid` & `result_ready`. The next point's SETTLE starts the following cycle; `result_valid` is low there.
- `filter_data` is sampled as presented at the clock edge; filter latency is covered by `cfg_settle`.

## Test plan
- Basic sweep: start=0, end=4, inc=2, settle=3, measure=5, `result_ready` tied to 1.
  - Expect three results, with delays 0, 2, 4.
  - Expect one `done` pulse and `busy` high for 3×(8+1)+1 cycles.
- Peak/tie: `filter_data` = -5, 7, 3, 7, -1.
  - Expect peak=7 and pos=1.
  - All-negative input -9, -3, -3 gives peak=-3, pos=1.
- Backpressure: hold `result_ready`=0 for 10 cycles.
  - `result_valid` and its fields stay stable, and `test_rate`=0 meanwhile.
  - The next point starts the cycle after ready rises.
- Overflow/degenerate cases:
  - start=250, end=255, inc=4 gives delays 250, 254 only.
  - end < start gives a single point.
  - inc=0 steps by 1.
  - measure=0 gives one sample.
- Abort/reset: assert `abort` during MEASURE, and separately `reset` during REPORT.
  - Expect IDLE the next cycle with `result_valid`=0 and no `done`.
  - A new `start` then runs a full sweep correctly.
- Config isolation: change `cfg_*` and pulse `start` mid-sweep.
  - The sweep continues unchanged using the latched values.
